panel_button_scanner: RTL and testbench

//  Debounces the front-panel push buttons (nav keys, ST[5:0], REX, DN_RIN) and queues

---
 rtl/panel_button_scanner.sv | 163 ++++++++++++++++
 tb/tb_panel_button_scanner.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/panel_button_scanner.sv
// Front-panel button debouncer with a press/release event queue behind an Avalon-MM slave.
// Flips that land while a button already has an unqueued event are merged and flagged.
module panel_button_scanner #(
  parameter int N_BUTTONS      = 16,
  parameter int ACTIVE_LOW     = 1,
  parameter int TICK_DIV       = 5000,
  parameter int DEBOUNCE_TICKS = 8,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                 csi_MCLK_clk,
  input  logic                 rsi_MCLK_reset_n,
  input  logic [N_BUTTONS-1:0] coe_buttons,
  input  logic [1:0]           avs_address,
  input  logic                 avs_read,
  input  logic                 avs_write,
  input  logic [31:0]          avs_writedata,
  output logic [31:0]          avs_readdata,
  output logic                 ins_irq
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [N_BUTTONS-1:0] RELEASED = {N_BUTTONS{ACTIVE_LOW != 0}};

  logic clk, rst_n;
  assign clk   = csi_MCLK_clk;
  assign rst_n = rsi_MCLK_reset_n;

  logic [N_BUTTONS-1:0] sync1_q, sync2_q, sample;
  logic [PW-1:0]        presc_q, presc_d;
  logic                 tick;
  logic [N_BUTTONS-1:0] db_q, db_d, pending_q, pending_d, flip, clr, clr_mask;
  logic                 ovf_q, ovf_d, irq_en_q, irq_en_d, irq_q;
  logic [7:0]           sel_idx;
  logic                 sel_pressed, push, pop, reg3_wr;
  logic [8:0]           mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [31:0]          readdata_q, readdata_d;
  logic                 unused_wdata;

  assign unused_wdata = &{1'b0, avs_writedata[31:2]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= RELEASED;
      sync2_q <= RELEASED;
    end else begin
      sync1_q <= coe_buttons;
      sync2_q <= sync1_q;
    end
  end

  assign sample  = (ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;
  assign tick    = (presc_q == PW'(TICK_DIV - 1));
  assign presc_d = tick ? '0 : presc_q + PW'(1);

  genvar gi;
  generate
    for (gi = 0; gi < N_BUTTONS; gi++) begin : g_btn
      logic [3:0] cnt_q, cnt_d;

      assign flip[gi] = tick && (sample[gi] != db_q[gi]) &&
                        (cnt_q == 4'(DEBOUNCE_TICKS - 1));

      always_comb begin
        cnt_d = cnt_q;
        if (tick) begin
          if (sample[gi] == db_q[gi] || flip[gi]) cnt_d = '0;
          else                                    cnt_d = cnt_q + 4'd1;
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
      end
    end
  endgenerate

  // Lowest-index pending button wins the single enqueue slot.
  always_comb begin
    sel_idx     = '0;
    sel_pressed = 1'b0;
    clr         = '0;
    for (int i = N_BUTTONS - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        sel_idx     = 8'(i);
        sel_pressed = db_q[i];
        clr         = '0;
        clr[i]      = 1'b1;
      end
    end
  end

  assign pop      = avs_read && (avs_address == 2'd1) && (count_q != '0);
  assign push     = (|pending_q) && ((count_q < CW'(FIFO_DEPTH)) || pop);
  assign clr_mask = {N_BUTTONS{push}} & clr;
  assign reg3_wr  = avs_write && (avs_address == 2'd3);

  // A flip on the button being pushed this cycle re-arms pending without counting as a merge.
  assign db_d      = db_q ^ flip;
  assign pending_d = (pending_q & ~clr_mask) | flip;
  assign ovf_d     = (|(flip & pending_q & ~clr_mask)) |
                     (ovf_q & ~(reg3_wr && avs_writedata[1]));
  assign irq_en_d  = reg3_wr ? avs_writedata[0] : irq_en_q;
  assign wr_ptr_d  = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
  assign rd_ptr_d  = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

  always_comb begin
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    readdata_d = readdata_q;
    if (avs_read) begin
      case (avs_address)
        2'd0:    readdata_d = 32'(db_q);
        2'd1:    readdata_d = (count_q != '0) ? {1'b1, 22'd0, mem_q[rd_ptr_q]} : 32'd0;
        2'd2:    readdata_d = {15'd0, ovf_q, 9'd0, 7'(count_q)};
        default: readdata_d = {31'd0, irq_en_q};
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {sel_pressed, sel_idx};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q    <= '0;
      db_q       <= '0;
      pending_q  <= '0;
      ovf_q      <= 1'b0;
      irq_en_q   <= 1'b0;
      irq_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      readdata_q <= '0;
    end else begin
      presc_q    <= presc_d;
      db_q       <= db_d;
      pending_q  <= pending_d;
      ovf_q      <= ovf_d;
      irq_en_q   <= irq_en_d;
      irq_q      <= (count_q != '0) && irq_en_q;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      readdata_q <= readdata_d;
    end
  end

  assign avs_readdata = readdata_q;
  assign ins_irq      = irq_q;

endmodule

// File: tb/tb_panel_button_scanner.sv
// Directed bench: reads queue their expected word; a monitor compares the registered readdata.
module tb_panel_button_scanner;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] buttons = 16'hFFFF;
  logic [1:0]  avs_address = 2'd0;
  logic        avs_read = 1'b0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = 32'd0;
  logic [31:0] avs_readdata;
  logic        ins_irq;

  int          n_checks = 0;
  int          n_fail = 0;
  logic        rd_fire = 1'b0;
  logic [31:0] exp_q[$];
  string       name_q[$];

  panel_button_scanner #(
    .N_BUTTONS(16), .ACTIVE_LOW(1), .TICK_DIV(4), .DEBOUNCE_TICKS(3), .FIFO_DEPTH(4)
  ) dut (
    .csi_MCLK_clk(clk),
    .rsi_MCLK_reset_n(rst_n),
    .coe_buttons(buttons),
    .avs_address(avs_address),
    .avs_read(avs_read),
    .avs_write(avs_write),
    .avs_writedata(avs_writedata),
    .avs_readdata(avs_readdata),
    .ins_irq(ins_irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", nm, got);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_read(input logic [1:0] a, input logic [31:0] exp, input string nm);
    @(negedge clk);
    exp_q.push_back(exp);
    name_q.push_back(nm);
    avs_address = a;
    avs_read    = 1'b1;
    @(negedge clk);
    avs_read    = 1'b0;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    avs_address   = a;
    avs_writedata = d;
    avs_write     = 1'b1;
    @(negedge clk);
    avs_write     = 1'b0;
    $display("write addr %0d data 0x%08h", a, d);
  endtask

  always @(posedge clk) rd_fire <= avs_read;

  always @(negedge clk) begin
    if (rd_fire) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_read: got 0x%08h expected no read", avs_readdata);
      end else begin
        chk(name_q.pop_front(), avs_readdata, exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    cycles(4);
    rst_n = 1'b1;
    chk("reset_readdata", avs_readdata, 32'd0);
    chk("reset_irq", {31'd0, ins_irq}, 32'd0);
    bus_read(2'd0, 32'd0, "reset_state");
    bus_read(2'd1, 32'd0, "reset_fifo_empty");
    bus_read(2'd2, 32'd0, "reset_status");
    bus_read(2'd3, 32'd0, "reset_ctrl");

    // 1: single press and release of button 5
    buttons[5] = 1'b0;
    cycles(24);
    bus_read(2'd0, 32'h0000_0020, "t1_state");
    bus_read(2'd1, 32'h8000_0105, "t1_press_evt");
    bus_read(2'd1, 32'h0000_0000, "t1_empty_pop");
    bus_read(2'd2, 32'h0000_0000, "t1_status");
    buttons[5] = 1'b1;
    cycles(24);
    bus_read(2'd1, 32'h8000_0005, "t1_release_evt");
    bus_read(2'd0, 32'h0000_0000, "t1_state_rel");

    // 2: bouncing button 2 never settles
    for (int i = 0; i < 10; i++) begin
      buttons[2] = 1'b0;
      cycles(4);
      buttons[2] = 1'b1;
      cycles(4);
    end
    cycles(24);
    bus_read(2'd0, 32'h0000_0000, "t2_bounce_state");
    bus_read(2'd2, 32'h0000_0000, "t2_bounce_count");
    buttons[2] = 1'b0;
    cycles(24);
    bus_read(2'd1, 32'h8000_0102, "t2_press_evt");
    buttons[2] = 1'b1;
    cycles(24);
    bus_read(2'd1, 32'h8000_0002, "t2_release_evt");

    // 3: simultaneous presses, irq until last pop
    bus_write(2'd3, 32'd1);
    bus_read(2'd3, 32'h0000_0001, "t3_irq_en");
    buttons[0] = 1'b0; buttons[3] = 1'b0; buttons[9] = 1'b0;
    cycles(24);
    chk("t3_irq_high", {31'd0, ins_irq}, 32'd1);
    bus_read(2'd2, 32'h0000_0003, "t3_count");
    bus_read(2'd1, 32'h8000_0100, "t3_evt0");
    bus_read(2'd1, 32'h8000_0103, "t3_evt3");
    chk("t3_irq_mid", {31'd0, ins_irq}, 32'd1);
    bus_read(2'd1, 32'h8000_0109, "t3_evt9");
    chk("t3_irq_at_last_pop", {31'd0, ins_irq}, 32'd1);
    cycles(1);
    chk("t3_irq_low", {31'd0, ins_irq}, 32'd0);

    // 4: full FIFO holds a fifth event until a pop
    buttons[0] = 1'b1; buttons[3] = 1'b1; buttons[9] = 1'b1; buttons[11] = 1'b0;
    cycles(24);
    bus_read(2'd2, 32'h0000_0004, "t4_full");
    buttons[7] = 1'b0;
    cycles(24);
    bus_read(2'd2, 32'h0000_0004, "t4_still_full");
    bus_read(2'd1, 32'h8000_0000, "t4_pop0");
    bus_read(2'd2, 32'h0000_0004, "t4_refilled");
    bus_read(2'd1, 32'h8000_0003, "t4_pop3");
    bus_read(2'd1, 32'h8000_0009, "t4_pop9");
    bus_read(2'd1, 32'h8000_010B, "t4_pop11");
    bus_read(2'd1, 32'h8000_0107, "t4_pop7");
    bus_read(2'd1, 32'h0000_0000, "t4_drained");
    cycles(2);
    chk("t4_irq_low", {31'd0, ins_irq}, 32'd0);

    // 5: coalesced press+release while FIFO full sets overflow
    buttons[7] = 1'b1; buttons[11] = 1'b1; buttons[12] = 1'b0; buttons[13] = 1'b0;
    cycles(24);
    buttons[1] = 1'b0;
    cycles(24);
    buttons[1] = 1'b1;
    cycles(24);
    bus_read(2'd2, 32'h0001_0004, "t5_overflow");
    bus_read(2'd1, 32'h8000_0007, "t5_pop7");
    bus_write(2'd3, 32'h2);
    bus_read(2'd2, 32'h0000_0004, "t5_ovf_cleared");
    bus_read(2'd3, 32'h0000_0000, "t5_ctrl");
    cycles(2);
    chk("t5_irq_disabled", {31'd0, ins_irq}, 32'd0);

    // 6: reset with events queued, button 4 held through it
    bus_read(2'd1, 32'h8000_000B, "t6_pop11");
    bus_write(2'd3, 32'd1);
    cycles(2);
    chk("t6_irq_before_reset", {31'd0, ins_irq}, 32'd1);
    bus_read(2'd2, 32'h0000_0003, "t6_count3");
    buttons[4] = 1'b0;
    cycles(6);
    rst_n = 1'b0;
    cycles(1);
    rst_n = 1'b1;
    chk("t6_reset_readdata", avs_readdata, 32'd0);
    chk("t6_reset_irq", {31'd0, ins_irq}, 32'd0);
    bus_read(2'd2, 32'h0000_0000, "t6_reset_count");
    bus_read(2'd3, 32'h0000_0000, "t6_reset_ctrl");
    cycles(24);
    bus_read(2'd2, 32'h0000_0003, "t6_fresh_count");
    bus_read(2'd0, 32'h0000_3010, "t6_state");
    bus_read(2'd1, 32'h8000_0104, "t6_evt4");
    bus_read(2'd1, 32'h8000_010C, "t6_evt12");
    bus_read(2'd1, 32'h8000_010D, "t6_evt13");
    bus_read(2'd2, 32'h0000_0000, "t6_empty");

    cycles(3);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
